// File: rtl/bgd_mul_pkg.sv
// Shared defaults and tag type for the BGD multiplier scheduler.
// The tag id width follows the default requester count.
package bgd_mul_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 13;
  localparam int unsigned MUL_LAT_DEF = 3;
  localparam int unsigned ID_W        = $clog2(NUM_REQ_DEF);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/bgd_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr with wrap.
// Grants only while en is high; the pointer moves past the winner.
module bgd_rr_arbiter
  import bgd_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ARB_ID_W = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                en,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ARB_ID_W-1:0] gnt_id
);

  localparam logic [ARB_ID_W:0]   NumReqW = (ARB_ID_W + 1)'(NUM_REQ);
  localparam logic [ARB_ID_W-1:0] LastId  = ARB_ID_W'(NUM_REQ - 1);

  logic [ARB_ID_W-1:0] ptr_q, ptr_d;
  logic [ARB_ID_W:0]   sum;
  logic [ARB_ID_W-1:0] idx;
  logic                found;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // ptr_q < NUM_REQ, so a single subtraction wraps the index
      sum = {1'b0, ptr_q} + (ARB_ID_W + 1)'(k);
      if (sum >= NumReqW) begin
        sum = sum - NumReqW;
      end
      idx = sum[ARB_ID_W-1:0];
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_id == LastId) ? '0 : gnt_id + ARB_ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bgd_mul_scheduler.sv
// Shares one pipelined signed multiplier among NUM_REQ requesters and
// routes each product back to its owner via a shadow tag pipeline.
module bgd_mul_scheduler
  import bgd_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mul_ce,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [DATA_W-1:0]         mul_p,
  output logic                      busy
);

  tag_t            tag_q [MUL_LAT];
  tag_t            tag_in;
  tag_t            head;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] gnt_id;
  logic            stall;
  logic            arb_en;

  assign head   = tag_q[MUL_LAT-1];
  assign stall  = head.valid & ~rsp_ready[head.id];
  assign mul_ce = ~stall;
  // Holding reset must also silence the combinational grant path.
  assign arb_en = mul_ce & reset_n;

  bgd_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ARB_ID_W (ID_W)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .en      (arb_en),
    .grant   (grant),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    req_ready    = grant;
    tag_in       = '0;
    tag_in.valid = |grant;
    tag_in.id    = gnt_id;
    mul_a        = '0;
    mul_b        = '0;
    if (|grant) begin
      mul_a = req_a[gnt_id*DATA_W +: DATA_W];
      mul_b = req_b[gnt_id*DATA_W +: DATA_W];
    end
  end

  // Advances in lock-step with the external multiplier registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else if (mul_ce) begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (head.valid && head.id == ID_W'(i)) begin
        rsp_valid[i] = 1'b1;
      end
    end
  end

  assign rsp_data = mul_p;

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < MUL_LAT; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

endmodule

// File: tb/tb_bgd_mul_scheduler.sv
// Directed bench for bgd_mul_scheduler with an external multiplier model
// and a grant-order scoreboard checked on every response handshake.
module tb_bgd_mul_scheduler;

  localparam int N   = 4;
  localparam int W   = 13;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     rsp_data, mul_a, mul_b, mul_p;
  logic             mul_ce, busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         id;
    logic [W-1:0] prod;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         rsp_cnt [N];
  int         snap [N];
  int         mid, gid;
  logic [W-1:0] mpipe [LAT];

  always #5 clk = ~clk;

  bgd_mul_scheduler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mul_ce    (mul_ce),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  function automatic logic [W-1:0] mul_trunc(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] f;
    f = $signed(a) * $signed(b);
    return f[W-1:0];
  endfunction

  function automatic int oh2id(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // External pipelined multiplier, frozen by mul_ce.
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= mul_trunc(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_p = mpipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push at grant, pop at response handshake.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (rsp_valid != '0) begin
        check("rsp_onehot", 32'($onehot(rsp_valid)), 1);
        if ((rsp_valid & rsp_ready) != '0) begin
          mid = oh2id(rsp_valid);
          check("rsp_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_id", mid, e.id);
            check("rsp_prod", rsp_data, e.prod);
            rsp_cnt[mid]++;
          end
        end
      end
      if (req_ready != '0) begin
        check("gnt_onehot", 32'($onehot(req_ready)), 1);
        check("gnt_valid", 32'((req_ready & ~req_valid) == '0), 1);
        gid = oh2id(req_ready);
        sb.push_back('{gid, mul_trunc(req_a[gid*W +: W], req_b[gid*W +: W])});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy, 0);
  endtask

  logic [15:0] pat;
  logic [2:0]  hist;

  initial begin
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    #3;
    req_valid = '1;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mul_ce", mul_ce, 1);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_busy", busy, 0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single requester, latency 3
    set_op(0, 13'd3, 13'h1FFB);
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_gnt", req_ready, 4'b0001);
    check("single_mul_a", mul_a, 13'd3);
    check("single_mul_b", mul_b, 13'h1FFB);
    check("single_busy0", busy, 0);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single_lat1", rsp_valid, 0);
    check("single_busy1", busy, 1);
    @(negedge clk);
    check("single_lat2", rsp_valid, 0);
    @(negedge clk);
    check("single_lat3", rsp_valid, 4'b0001);
    check("single_data", rsp_data, 13'h1FF1);
    @(negedge clk);
    check("single_lat4", rsp_valid, 0);

    // Wrapping products
    tick();
    set_op(1, 13'd100, 13'd100);
    req_valid = 4'b0010;
    @(negedge clk);
    check("wrap_gnt1", req_ready, 4'b0010);
    tick();
    set_op(2, 13'h1000, 13'h1FFF);
    req_valid = 4'b0100;
    @(negedge clk);
    check("wrap_gnt2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("wrap_rsp1", rsp_valid, 4'b0010);
    check("wrap_data1", rsp_data, 13'd1808);
    @(negedge clk);
    check("wrap_rsp2", rsp_valid, 4'b0100);
    check("wrap_data2", rsp_data, 13'h1000);

    // Full contention from reset
    tick();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) snap[i] = rsp_cnt[i];
    req_valid = '1;
    rand_ops();
    for (int k = 0; k < 12; k++) begin
      logic [N-1:0] exp_rr;
      exp_rr = N'(1) << (k % N);
      @(negedge clk);
      check("rr_grant", req_ready, exp_rr);
      tick();
      rand_ops();
    end
    req_valid = '0;
    drain("rr_drain");
    for (int i = 0; i < N; i++) check("rr_rsp_count", rsp_cnt[i] - snap[i], 3);
    check("rr_sb_empty", sb.size(), 0);

    // Back-pressure on requester 1
    tick();
    snap[1] = rsp_cnt[1];
    set_op(1, 13'd77, 13'h1FFD);
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    @(negedge clk);
    check("bp_gnt", req_ready, 4'b0010);
    tick();
    set_op(0, 13'd5, 13'd6);
    req_valid = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("bp_ce", mul_ce, 0);
      check("bp_ready", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 4'b0010);
      check("bp_rsp_data", rsp_data, 13'h1F19);
    end
    tick();
    rsp_ready = '1;
    @(negedge clk);
    check("bp_release_ce", mul_ce, 1);
    check("bp_release_rsp", rsp_valid, 4'b0010);
    check("bp_release_gnt", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    drain("bp_drain");
    check("bp_rsp_once", rsp_cnt[1] - snap[1], 1);
    check("bp_sb_empty", sb.size(), 0);

    // Reset with three operations in flight
    tick();
    rand_ops();
    req_valid = 4'b0110;
    @(negedge clk);
    check("mid_gnt_a", req_ready, 4'b0010);
    tick();
    @(negedge clk);
    check("mid_gnt_b", req_ready, 4'b0100);
    tick();
    @(negedge clk);
    check("mid_gnt_c", req_ready, 4'b0010);
    check("mid_busy", busy, 1);
    tick();
    reset_n   = 1'b0;
    req_valid = '0;
    sb.delete();
    #1;
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("mid_quiet", rsp_valid, 0);
    end
    tick();
    rand_ops();
    req_valid = '1;
    @(negedge clk);
    check("mid_first_gnt", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    drain("mid_drain");

    // Sparse traffic on requester 2
    tick();
    pat  = 16'b0000_0100_0010_1011;
    hist = '0;
    for (int k = 0; k < 16; k++) begin
      req_valid = pat[k] ? 4'b0100 : 4'b0000;
      set_op(2, W'(k + 1), W'(k + 2));
      @(negedge clk);
      check("sparse_gnt", req_ready, pat[k] ? 4'b0100 : 4'b0000);
      check("sparse_rsp", rsp_valid, hist[2] ? 4'b0100 : 4'b0000);
      check("sparse_busy", busy, |hist);
      hist = {hist[1:0], pat[k]};
      tick();
    end
    req_valid = '0;
    drain("sparse_drain");
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
